// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Imported by ctrl_decode and multicycle_ctrl.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_LUI = 4'b1001;

    localparam logic [2:0] BR_NONE   = 3'b010;
    localparam logic [2:0] BR_ALWAYS = 3'b011;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_LINK = 2'b10;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_IMEM    = 2'b10;
    localparam logic [1:0] TC_DMEM    = 2'b11;

    // Decoded instruction: datapath controls plus the class bits the FSM needs later.
    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] branch_cond;
        logic [2:0] data_size;
        logic [1:0] mem_to_reg;
        logic       alu_a_src;
        logic       alu_b_src;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       illegal;
    } dec_t;

    localparam dec_t DEC_RESET = '{
        alu_op:      ALU_ADD,
        branch_cond: BR_NONE,
        data_size:   3'b000,
        mem_to_reg:  M2R_ALU,
        alu_a_src:   1'b0,
        alu_b_src:   1'b0,
        is_load:     1'b0,
        is_store:    1'b0,
        is_branch:   1'b0,
        illegal:     1'b0
    };

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field, memory-handshake and control-strobe bundle of multicycle_ctrl.
// master = the controller, slave = datapath/memory side.
interface multicycle_ctrl_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       imem_req;
    logic       imem_ack;
    logic       dmem_req;
    logic       dmem_ack;
    logic       trap_ack;
    logic [3:0] alu_op;
    logic [2:0] branch_cond;
    logic [2:0] data_size;
    logic [1:0] mem_to_reg;
    logic       alu_a_src;
    logic       alu_b_src;
    logic       ir_write_en;
    logic       pc_write_en;
    logic       reg_write_en;
    logic       data_read_en;
    logic       data_write_en;
    logic       busy;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  opcode, funct3, funct7, imem_ack, dmem_ack, trap_ack,
        output imem_req, dmem_req, alu_op, branch_cond, data_size, mem_to_reg,
               alu_a_src, alu_b_src, ir_write_en, pc_write_en, reg_write_en,
               data_read_en, data_write_en, busy, trap, trap_cause
    );

    modport slave (
        output opcode, funct3, funct7, imem_ack, dmem_ack, trap_ack,
        input  imem_req, dmem_req, alu_op, branch_cond, data_size, mem_to_reg,
               alu_a_src, alu_b_src, ir_write_en, pc_write_en, reg_write_en,
               data_read_en, data_write_en, busy, trap, trap_cause
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational RV32I opcode decode; any opcode outside the 9 base
// opcodes is flagged illegal.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_b5,
    output dec_t       o_dec
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        o_dec           = DEC_RESET;
        o_dec.alu_b_src = 1'b1;
        unique case (i_opcode)
            OPC_OP_IMM: o_dec.alu_op = {i_funct7_b5, i_funct3};
            OPC_OP: begin
                o_dec.alu_op    = {i_funct7_b5, i_funct3};
                o_dec.alu_b_src = 1'b0;
            end
            OPC_LUI:   o_dec.alu_op    = ALU_LUI;
            OPC_AUIPC: o_dec.alu_a_src = 1'b1;
            OPC_JAL: begin
                o_dec.branch_cond = BR_ALWAYS;
                o_dec.mem_to_reg  = M2R_LINK;
                o_dec.alu_a_src   = 1'b1;
            end
            OPC_JALR: begin
                o_dec.branch_cond = BR_ALWAYS;
                o_dec.mem_to_reg  = M2R_LINK;
            end
            OPC_BRANCH: begin
                o_dec.branch_cond = i_funct3;
                o_dec.alu_a_src   = 1'b1;
                o_dec.is_branch   = 1'b1;
            end
            OPC_LOAD: begin
                o_dec.data_size  = i_funct3;
                o_dec.mem_to_reg = M2R_MEM;
                o_dec.is_load    = 1'b1;
            end
            OPC_STORE: begin
                o_dec.data_size = i_funct3;
                o_dec.is_store  = 1'b1;
            end
            default: o_dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with registered decode and memory-ack timeout.
// Define ILLEGAL_TRAP_EN to route faults into a TRAP state instead of skipping the instruction.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMR_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    dec_t             r_dec;
    dec_t             w_dec;
    logic [TMR_W-1:0] r_tmr;
    logic             w_tmr_last;
    logic             w_tmr_count;
    logic             w_fault;
    logic [1:0]       w_fault_cause;
    logic             w_imem_req;
    logic             w_dmem_req;
    logic             w_ir_write_en;
    logic             w_pc_write_en;
    logic             w_reg_write_en;
    logic             w_data_read_en;
    logic             w_data_write_en;
    logic             w_unused;

    ctrl_decode u_decode (
        .i_opcode    (bus.opcode),
        .i_funct3    (bus.funct3),
        .i_funct7_b5 (bus.funct7[5]),
        .o_dec       (w_dec)
    );

    // The MEM_TIMEOUT-th ack-less cycle faults unless the ack arrives in that same cycle.
    assign w_tmr_last  = (r_tmr == TMR_W'(MEM_TIMEOUT - 1));
    assign w_tmr_count = ((r_state == ST_FETCH) && !bus.imem_ack) ||
                         ((r_state == ST_MEM)   && !bus.dmem_ack);

    always_comb begin
        w_state_nxt     = r_state;
        w_imem_req      = 1'b0;
        w_dmem_req      = 1'b0;
        w_ir_write_en   = 1'b0;
        w_pc_write_en   = 1'b0;
        w_reg_write_en  = 1'b0;
        w_data_read_en  = 1'b0;
        w_data_write_en = 1'b0;
        w_fault         = 1'b0;
        w_fault_cause   = TC_NONE;
        if (!rst) begin
            unique case (r_state)
                ST_FETCH: begin
                    w_imem_req = 1'b1;
                    if (bus.imem_ack) begin
                        w_ir_write_en = 1'b1;
                        w_state_nxt   = ST_DECODE;
                    end else if (w_tmr_last) begin
                        w_fault       = 1'b1;
                        w_fault_cause = TC_IMEM;
                    end
                end
                ST_DECODE: begin
                    if (w_dec.illegal) begin
                        w_fault       = 1'b1;
                        w_fault_cause = TC_ILLEGAL;
                    end else begin
                        w_state_nxt = ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (r_dec.is_load || r_dec.is_store) begin
                        w_state_nxt = ST_MEM;
                    end else if (r_dec.is_branch) begin
                        w_pc_write_en = 1'b1;
                        w_state_nxt   = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    w_dmem_req      = 1'b1;
                    w_data_read_en  = r_dec.is_load;
                    w_data_write_en = r_dec.is_store;
                    if (bus.dmem_ack) begin
                        if (r_dec.is_load) begin
                            w_state_nxt = ST_WRITEBACK;
                        end else begin
                            w_pc_write_en = 1'b1;
                            w_state_nxt   = ST_FETCH;
                        end
                    end else if (w_tmr_last) begin
                        w_fault       = 1'b1;
                        w_fault_cause = TC_DMEM;
                    end
                end
                ST_WRITEBACK: begin
                    w_reg_write_en = 1'b1;
                    w_pc_write_en  = 1'b1;
                    w_state_nxt    = ST_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: if (bus.trap_ack) w_state_nxt = ST_FETCH;
`else
                ST_TRAP: w_state_nxt = ST_FETCH;
`endif
                default: w_state_nxt = ST_FETCH;
            endcase
            if (w_fault) begin
`ifdef ILLEGAL_TRAP_EN
                w_state_nxt = ST_TRAP;
`else
                w_pc_write_en = 1'b1;
                w_state_nxt   = ST_FETCH;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            r_state <= ST_FETCH;
            r_dec   <= DEC_RESET;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_DECODE) r_dec <= w_dec;
            // Any state change (including a fault re-entering FETCH) starts a fresh wait window.
            if ((w_state_nxt != r_state) || w_fault) r_tmr <= '0;
            else if (w_tmr_count)                    r_tmr <= r_tmr + TMR_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic [1:0] r_trap_cause;

    always_ff @(posedge clk) begin
        if (rst)                                         r_trap_cause <= TC_NONE;
        else if (w_fault)                                r_trap_cause <= w_fault_cause;
        else if ((r_state == ST_TRAP) && bus.trap_ack)   r_trap_cause <= TC_NONE;
    end

    assign bus.trap       = !rst && (r_state == ST_TRAP);
    assign bus.trap_cause = rst ? TC_NONE : r_trap_cause;
    assign w_unused       = ^{bus.funct7[6], bus.funct7[4:0], r_dec.illegal};
`else
    assign bus.trap       = 1'b0;
    assign bus.trap_cause = TC_NONE;
    assign w_unused       = ^{bus.funct7[6], bus.funct7[4:0], r_dec.illegal,
                              bus.trap_ack, w_fault_cause};
`endif

    assign bus.imem_req      = w_imem_req;
    assign bus.dmem_req      = w_dmem_req;
    assign bus.ir_write_en   = w_ir_write_en;
    assign bus.pc_write_en   = w_pc_write_en;
    assign bus.reg_write_en  = w_reg_write_en;
    assign bus.data_read_en  = w_data_read_en;
    assign bus.data_write_en = w_data_write_en;
    assign bus.busy          = !rst && (r_state != ST_FETCH);
    assign bus.alu_op        = r_dec.alu_op;
    assign bus.branch_cond   = r_dec.branch_cond;
    assign bus.data_size     = r_dec.data_size;
    assign bus.mem_to_reg    = r_dec.mem_to_reg;
    assign bus.alu_a_src     = r_dec.alu_a_src;
    assign bus.alu_b_src     = r_dec.alu_b_src;

endmodule
